// File: rtl/tft_pixel_streamer.sv
// ---------------------------------------------------------------------------
// tft_pixel_streamer
//
// Purpose:
//    Pixel-clock stage that sits right after the TFT timing controller. It
//    turns the controller's horizontal/vertical counters into the panel
//    data-enable and RGB bus. During the active area it pops one pixel per
//    clock from an upstream FIFO through a valid/ready handshake. When the
//    FIFO runs dry inside the active area, the pixel is blanked to BG_COLOR
//    and the rest of the frame stays at BG_COLOR. The block also pulses a
//    flush request upstream and picks streaming up again at the next frame
//    start.
//
// Ports:
//    i_pixel_clk       pixel clock, all logic on the rising edge
//    i_reset           asynchronous active-high reset
//    i_enabled         streaming enable (already in the pixel clock domain)
//    i_counter_h       horizontal counter from the timing controller
//    i_counter_v       vertical counter from the timing controller
//    i_pixel_data      upstream FIFO head pixel
//    i_pixel_valid     upstream FIFO head valid
//    o_pixel_ready     pop strobe (combinational), transfer on valid & ready
//    o_frame_start     one-cycle pulse, registered copy of (0,0) while enabled
//    o_flush           one-cycle pulse asking upstream to drop the frame
//    o_tft_de          panel data enable
//    o_tft_rgb         panel pixel data
//    o_underrun        sticky underrun flag
//    o_underrun_count  saturating underrun event counter
// ---------------------------------------------------------------------------
module tft_pixel_streamer #(
    parameter int                    H_ACTIVE_START = 160,
    parameter int                    H_ACTIVE       = 1024,
    parameter int                    V_ACTIVE_START = 23,
    parameter int                    V_ACTIVE       = 600,
    parameter int                    PIXEL_BITS     = 16,
    parameter logic [PIXEL_BITS-1:0] BG_COLOR       = 16'h0000
) (
    input  logic                  i_pixel_clk,
    input  logic                  i_reset,
    input  logic                  i_enabled,
    input  logic [10:0]           i_counter_h,
    input  logic [9:0]            i_counter_v,
    input  logic [PIXEL_BITS-1:0] i_pixel_data,
    input  logic                  i_pixel_valid,
    output logic                  o_pixel_ready,
    output logic                  o_frame_start,
    output logic                  o_flush,
    output logic                  o_tft_de,
    output logic [PIXEL_BITS-1:0] o_tft_rgb,
    output logic                  o_underrun,
    output logic [7:0]            o_underrun_count
);

    // Inclusive window bounds, precomputed so the compare is a pure range
    // check on the raw counters with no arithmetic on the live values.
    localparam logic [10:0] H_FIRST = 11'(H_ACTIVE_START);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE_START + H_ACTIVE - 1);
    localparam logic [9:0]  V_FIRST = 10'(V_ACTIVE_START);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE_START + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_STREAM,
        ST_RESYNC
    } state_t;

    state_t                r_state;
    logic                  r_frameStart;
    logic                  r_flush;
    logic                  r_de;
    logic [PIXEL_BITS-1:0] r_rgb;
    logic                  r_underrun;
    logic [7:0]            r_underrunCount;

    logic w_active;
    logic w_fs;
    logic w_ready;
    logic w_transfer;
    logic w_underrun;

    // Decode of the current counter position. An underrun is only meaningful
    // while actively streaming; in RESYNC the FIFO is being flushed, so an
    // empty FIFO there is expected and is not counted again.
    always_comb begin
        w_active   = (i_counter_h >= H_FIRST) && (i_counter_h <= H_LAST) &&
                     (i_counter_v >= V_FIRST) && (i_counter_v <= V_LAST);
        w_fs       = i_enabled && (i_counter_h == 11'd0) && (i_counter_v == 10'd0);
        w_ready    = (r_state == ST_STREAM) && w_active;
        w_transfer = w_ready && i_pixel_valid;
        w_underrun = w_ready && !i_pixel_valid;
    end

    // Control state machine and the registered output stage together. The
    // pixel path runs regardless of enable so the panel always sees a clean
    // blank/pixel value. Dropping enable overrides every transition and
    // clears the underrun bookkeeping.
    always_ff @(posedge i_pixel_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_frameStart    <= 1'b0;
            r_flush         <= 1'b0;
            r_de            <= 1'b0;
            r_rgb           <= '0;
            r_underrun      <= 1'b0;
            r_underrunCount <= 8'd0;
        end else begin
            r_frameStart <= w_fs;
            r_de         <= w_active && ((r_state == ST_STREAM) || (r_state == ST_RESYNC));

            if (w_transfer) begin
                r_rgb <= i_pixel_data;
            end else if (w_active) begin
                r_rgb <= BG_COLOR;
            end else begin
                r_rgb <= '0;
            end

            if (!i_enabled) begin
                r_state         <= ST_IDLE;
                r_flush         <= 1'b0;
                r_underrun      <= 1'b0;
                r_underrunCount <= 8'd0;
            end else begin
                r_flush <= w_underrun;
                if (w_underrun) begin
                    r_underrun <= 1'b1;
                    if (r_underrunCount != 8'hFF) begin
                        r_underrunCount <= r_underrunCount + 8'd1;
                    end
                end

                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_WAIT_FRAME;
                    end
                    ST_WAIT_FRAME: begin
                        if (w_fs) begin
                            r_state <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (w_underrun) begin
                            r_state <= ST_RESYNC;
                        end
                    end
                    ST_RESYNC: begin
                        if (w_fs) begin
                            r_state <= ST_STREAM;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_pixel_ready    = w_ready;
    assign o_frame_start    = r_frameStart;
    assign o_flush          = r_flush;
    assign o_tft_de         = r_de;
    assign o_tft_rgb        = r_rgb;
    assign o_underrun       = r_underrun;
    assign o_underrun_count = r_underrunCount;

endmodule

// File: tb/tb_tft_pixel_streamer.sv
// ---------------------------------------------------------------------------
// tb_tft_pixel_streamer
//
// Purpose:
//    Self-checking bench for tft_pixel_streamer. The main instance runs with
//    a shrunken raster so that hundreds of whole frames fit in a short run.
//    The bench drives its own h/v counters, models the expected panel outputs
//    each cycle, pushes them into a scoreboard queue and compares them one
//    clock later. A second instance with the full-size default geometry is
//    poked directly at the active-window edges.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_tft_pixel_streamer;

    // Shrunken raster for the main instance.
    localparam int          TB_HS = 4;
    localparam int          TB_HA = 8;
    localparam int          TB_HT = 16;
    localparam int          TB_VS = 2;
    localparam int          TB_VA = 4;
    localparam int          TB_VT = 8;
    localparam int          TB_FRAME = TB_HT * TB_VT;
    localparam logic [15:0] TB_BG = 16'hA5A5;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STREAM = 2;
    localparam int M_RESYNC = 3;

    typedef struct packed {
        logic        de;
        logic [15:0] rgb;
        logic        fs;
        logic        flush;
        logic        urun;
        logic [7:0]  cnt;
    } outVec_t;

    logic        clock;
    logic        reset;
    logic        enabled;
    logic [10:0] counterH;
    logic [9:0]  counterV;
    logic [15:0] pixelData;
    logic        pixelValid;
    logic        pixelReady;
    logic        frameStart;
    logic        flush;
    logic        tftDe;
    logic [15:0] tftRgb;
    logic        underrun;
    logic [7:0]  underrunCount;

    logic        dEn;
    logic [10:0] dH;
    logic [9:0]  dV;
    logic [15:0] dData;
    logic        dReady;
    logic        dFs;
    logic        dFlush;
    logic        dDe;
    logic [15:0] dRgb;
    logic        dUrun;
    logic [7:0]  dCnt;

    int checks;
    int errors;

    // Stimulus generator state and reference model state.
    int          tbH;
    int          tbV;
    logic        tbEnabled;
    logic        dropArmed;
    int          dropH;
    int          dropV;
    logic [15:0] dataHead;
    int          mState;
    logic        mFlush;
    logic        mUrun;
    logic [7:0]  mCnt;
    int          popsSeen;
    int          flushSeen;
    logic        firstDeSeen;
    outVec_t     expQ[$];

    int dPtH[8]   = '{159, 160, 1183, 1184, 160, 160, 160, 1199};
    int dPtV[8]   = '{23, 23, 23, 23, 22, 622, 623, 686};
    logic dPtIn[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    tft_pixel_streamer #(
        .H_ACTIVE_START (TB_HS),
        .H_ACTIVE       (TB_HA),
        .V_ACTIVE_START (TB_VS),
        .V_ACTIVE       (TB_VA),
        .PIXEL_BITS     (16),
        .BG_COLOR       (TB_BG)
    ) u_dut (
        .i_pixel_clk      (clock),
        .i_reset          (reset),
        .i_enabled        (enabled),
        .i_counter_h      (counterH),
        .i_counter_v      (counterV),
        .i_pixel_data     (pixelData),
        .i_pixel_valid    (pixelValid),
        .o_pixel_ready    (pixelReady),
        .o_frame_start    (frameStart),
        .o_flush          (flush),
        .o_tft_de         (tftDe),
        .o_tft_rgb        (tftRgb),
        .o_underrun       (underrun),
        .o_underrun_count (underrunCount)
    );

    tft_pixel_streamer u_dutDef (
        .i_pixel_clk      (clock),
        .i_reset          (reset),
        .i_enabled        (dEn),
        .i_counter_h      (dH),
        .i_counter_v      (dV),
        .i_pixel_data     (dData),
        .i_pixel_valid    (1'b1),
        .o_pixel_ready    (dReady),
        .o_frame_start    (dFs),
        .o_flush          (dFlush),
        .o_tft_de         (dDe),
        .o_tft_rgb        (dRgb),
        .o_underrun       (dUrun),
        .o_underrun_count (dCnt)
    );

    // Free-running 100 MHz pixel clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic inWindow(input int h, input int v);
        return (h >= TB_HS) && (h < TB_HS + TB_HA) && (v >= TB_VS) && (v < TB_VS + TB_VA);
    endfunction

    function automatic outVec_t observeOutputs();
        outVec_t o;
        o.de    = tftDe;
        o.rgb   = tftRgb;
        o.fs    = frameStart;
        o.flush = flush;
        o.urun  = underrun;
        o.cnt   = underrunCount;
        return o;
    endfunction

    // One pixel clock: drive counters/handshake, check the combinational pop
    // strobe, push the expected registered outputs, then compare after the edge.
    task automatic applyStimulus();
        outVec_t expVec;
        outVec_t obsVec;
        logic    win;
        logic    fs;
        logic    rdy;
        logic    xfer;
        logic    urunNow;
        counterH   = 11'(tbH);
        counterV   = 10'(tbV);
        enabled    = tbEnabled;
        pixelValid = !(dropArmed && (tbH == dropH) && (tbV == dropV));
        pixelData  = dataHead;
        #1;
        win     = inWindow(tbH, tbV);
        fs      = tbEnabled && (tbH == 0) && (tbV == 0);
        rdy     = (mState == M_STREAM) && win;
        xfer    = rdy && pixelValid;
        urunNow = rdy && !pixelValid;
        checkOutput("ready", 32'(pixelReady), 32'(rdy));
        if (pixelReady && pixelValid) popsSeen++;

        expVec.de  = win && ((mState == M_STREAM) || (mState == M_RESYNC));
        expVec.rgb = xfer ? dataHead : (win ? TB_BG : 16'h0000);
        expVec.fs  = fs;
        if (!tbEnabled) begin
            mState = M_IDLE;
            mFlush = 1'b0;
            mUrun  = 1'b0;
            mCnt   = 8'd0;
        end else begin
            mFlush = urunNow;
            if (urunNow) begin
                mUrun = 1'b1;
                if (mCnt != 8'hFF) mCnt = mCnt + 8'd1;
            end
            case (mState)
                M_IDLE:   mState = M_WAIT;
                M_WAIT:   if (fs) mState = M_STREAM;
                M_STREAM: if (urunNow) mState = M_RESYNC;
                M_RESYNC: if (fs) mState = M_STREAM;
                default:  mState = M_IDLE;
            endcase
        end
        expVec.flush = mFlush;
        expVec.urun  = mUrun;
        expVec.cnt   = mCnt;
        expQ.push_back(expVec);
        if (xfer) dataHead = dataHead + 16'd1;

        @(posedge clock);
        #1;
        obsVec = observeOutputs();
        checkOutput("out", 32'(obsVec), 32'(expQ.pop_front()));
        if (flush) flushSeen++;
        if (tftDe && !firstDeSeen) begin
            firstDeSeen = 1'b1;
            checkOutput("firstPix", 32'(tftRgb), 32'h0);
        end

        if (tbH == TB_HT - 1) begin
            tbH = 0;
            tbV = (tbV == TB_VT - 1) ? 0 : tbV + 1;
        end else begin
            tbH = tbH + 1;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic runToFrameStart();
        for (int i = 0; i < TB_FRAME && !((tbH == 0) && (tbV == 0)); i++) applyStimulus();
    endtask

    task automatic runToPoint(input int h, input int v);
        for (int i = 0; i < TB_FRAME && !((tbH == h) && (tbV == v)); i++) applyStimulus();
    endtask

    // Full-size geometry: walk the default instance into STREAM, then probe
    // the active-window edges directly.
    task automatic checkDefaultWindow();
        dEn = 1'b1; dH = 11'd5; dV = 10'd5; dData = 16'h0;
        @(posedge clock); #1;
        dH = 11'd0; dV = 10'd0;
        @(posedge clock); #1;
        checkOutput("dFs", 32'(dFs), 32'h1);
        for (int i = 0; i < 8; i++) begin
            dH    = 11'(dPtH[i]);
            dV    = 10'(dPtV[i]);
            dData = 16'h1000 + 16'(i);
            #1;
            checkOutput("dReady", 32'(dReady), 32'(dPtIn[i]));
            @(posedge clock); #1;
            checkOutput("dDeRgb", 32'({dDe, dRgb}),
                        dPtIn[i] ? 32'({1'b1, 16'h1000 + 16'(i)}) : 32'h0);
        end
        dEn = 1'b0;
        @(posedge clock); #1;
    endtask

    // Async reset in the middle of a streaming line; outputs must clear
    // before the next clock edge.
    task automatic resetMidTransfer();
        counterH = 11'(tbH);
        counterV = 10'(tbV);
        pixelValid = 1'b1;
        #1;
        checkOutput("preRstReady", 32'(pixelReady), 32'(mState == M_STREAM && inWindow(tbH, tbV)));
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rstAsync", 32'({pixelReady, observeOutputs()}), 32'h0);
        expQ.delete();
        mState = M_IDLE;
        mFlush = 1'b0;
        mUrun  = 1'b0;
        mCnt   = 8'd0;
        @(posedge clock); #1;
        checkOutput("rstHeld", 32'({pixelReady, observeOutputs()}), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; enabled = 1'b0; counterH = '0; counterV = '0;
        pixelData = '0; pixelValid = 1'b0;
        dEn = 1'b0; dH = '0; dV = '0; dData = '0;
        tbH = 0; tbV = 0; tbEnabled = 1'b0; dropArmed = 1'b0; dropH = 0; dropV = 0;
        dataHead = 16'h0; mState = M_IDLE; mFlush = 1'b0; mUrun = 1'b0; mCnt = 8'd0;
        popsSeen = 0; flushSeen = 0; firstDeSeen = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("rstVal", 32'({pixelReady, observeOutputs()}), 32'h0);
        checkOutput("rstValDef", 32'({dReady, dFs, dFlush, dDe, dRgb, dUrun, dCnt}), 32'h0);
        reset = 1'b0;

        checkDefaultWindow();

        // Enable mid-frame with an always-valid FIFO: nothing shown until (0,0).
        tbH = 6; tbV = 3; tbEnabled = 1'b1;
        runToFrameStart();
        checkOutput("popsPreFs1", 32'(popsSeen), 32'h0);
        popsSeen = 0;
        runCycles(2 * TB_FRAME);
        checkOutput("pops2Frames", 32'(popsSeen), 32'(2 * TB_HA * TB_VA));
        checkOutput("urunClean", 32'({underrun, underrunCount}), 32'h0);
        checkOutput("firstDeSeen", 32'(firstDeSeen), 32'h1);

        // Single underrun mid-frame, then recovery on the following frame.
        dropArmed = 1'b1; dropH = 6; dropV = 3;
        popsSeen = 0; flushSeen = 0;
        runCycles(TB_FRAME);
        checkOutput("popsUrunFrame", 32'(popsSeen), 32'(TB_HA + 2));
        checkOutput("flushOnce", 32'(flushSeen), 32'h1);
        checkOutput("urunFlagCnt", 32'({underrun, underrunCount}), 32'h101);
        dropArmed = 1'b0;
        popsSeen = 0;
        runCycles(TB_FRAME);
        checkOutput("popsRecovered", 32'(popsSeen), 32'(TB_HA * TB_VA));

        // One underrun in each of 300 frames: the counter saturates.
        dropArmed = 1'b1;
        runCycles(300 * TB_FRAME);
        checkOutput("cntSaturate", 32'({underrun, underrunCount}), 32'h1FF);
        dropArmed = 1'b0;

        // Drop enable in the middle of an active line, then re-enable mid-frame.
        runToPoint(6, 3);
        tbEnabled = 1'b0;
        runCycles(2);
        checkOutput("disableClear", 32'({pixelReady, tftDe, underrun, underrunCount}), 32'h0);
        runCycles(5);
        tbEnabled = 1'b1;
        popsSeen = 0;
        runToFrameStart();
        checkOutput("popsPreFs2", 32'(popsSeen), 32'h0);
        runCycles(TB_FRAME);
        checkOutput("popsReenable", 32'(popsSeen), 32'(TB_HA * TB_VA));

        // Async reset mid-transfer, then the block must re-acquire a frame.
        runToPoint(TB_HS + 3, TB_VS + 1);
        resetMidTransfer();
        popsSeen = 0;
        runCycles(1);
        runToFrameStart();
        checkOutput("popsPreFs3", 32'(popsSeen), 32'h0);
        runCycles(TB_FRAME);
        checkOutput("popsAfterRst", 32'(popsSeen), 32'(TB_HA * TB_VA));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tft_pixel_streamer.md
Name: tft_pixel_streamer

Overview:
- Pixel-clock stage directly downstream of the TFT video timing controller.
- Consumes its horizontal/vertical counters and enable, and generates the panel data-enable (DE) and RGB bus.
- Pops one pixel per active-area clock from an upstream pixel FIFO through a valid/ready handshake.
- Detects FIFO underrun, blanks to a background colour for the rest of that frame, asks upstream to flush, and resynchronises at the next frame start.

Parameters:
- H_ACTIVE_START, 160, first horizontal count of the active area (pulse 10 + back porch 150)
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE_START, 23, first vertical count of the active area (pulse 2 + back porch 21)
- V_ACTIVE, 600, active lines per frame
- PIXEL_BITS, 16, RGB565 pixel width
- BG_COLOR, 16'h0000, colour driven in active area when no valid pixel is available

Ports:
- i_pixel_clk  input  1  pixel clock; all logic on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_enabled  input  1  streaming enable, already synchronous to i_pixel_clk
- i_counter_h  input  11  horizontal counter from timing controller, 0..1199
- i_counter_v  input  10  vertical counter from timing controller, 0..686
- i_pixel_data  input  PIXEL_BITS  upstream FIFO head pixel
- i_pixel_valid  input  1  FIFO head valid
- o_pixel_ready  output  1  pop strobe; transfer when valid and ready are both high
- o_frame_start  output  1  one-cycle pulse at the start of each frame while enabled
- o_flush  output  1  one-cycle pulse requesting upstream to discard the current frame
- o_tft_de  output  1  panel data enable
- o_tft_rgb  output  PIXEL_BITS  panel pixel data
- o_underrun  output  1  sticky underrun flag; cleared by reset or by i_enabled low
- o_underrun_count  output  8  saturating underrun event counter; cleared the same way

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Active window: w_active = (i_counter_h in [H_ACTIVE_START, H_ACTIVE_START+H_ACTIVE-1]) and (i_counter_v in [V_ACTIVE_START, V_ACTIVE_START+V_ACTIVE-1]).
  - Compare with ranges only; no arithmetic wrap is permitted.
- Frame start: w_fs = i_enabled and i_counter_h==0 and i_counter_v==0.
  - o_frame_start is the registered w_fs, giving 1 cycle latency.
- State machine:
  - IDLE: on i_enabled go to WAIT_FRAME.
  - WAIT_FRAME: on w_fs go to STREAM.
  - STREAM: if w_active and not i_pixel_valid, this is an underrun; go to RESYNC.
  - RESYNC: on w_fs go to STREAM.
  - Any state: i_enabled low forces IDLE next cycle and clears o_underrun and o_underrun_count.
- Ready: o_pixel_ready = (state==STREAM) and w_active, combinational. No pops occur outside STREAM or outside the active window.
- Output pipeline, registered, 1 cycle latency from counters:
  - o_tft_de <= w_active and state in {STREAM, RESYNC}.
  - o_tft_rgb <= i_pixel_data when a transfer occurs.
  - Otherwise o_tft_rgb <= BG_COLOR if w_active, else 0.
  - o_tft_de is 0 in IDLE and WAIT_FRAME, so a partial first frame is never shown.
- Underrun event: the cycle in STREAM with w_active and i_pixel_valid low.
  - That pixel outputs BG_COLOR with DE high.
  - o_underrun sets next cycle.
  - o_underrun_count increments next cycle, saturating at 255.
  - o_flush pulses next cycle for exactly 1 cycle.
- In RESYNC, DE and timing continue. Active pixels are BG_COLOR until the next w_fs, and no further underruns are counted.
- Simultaneous events:
  - w_fs and an underrun cannot coincide, because (0,0) lies outside the active window.
  - i_enabled falling has priority over all transitions.
  - Reset mid-line takes effect immediately (async).
- Valid high outside ready is ignored; data is held by upstream.

Test Plan:
- Reset, enable at h=500,v=300 with FIFO always valid, incrementing data:
  - no DE until frame start
  - o_frame_start pulses 1 cycle after (0,0)
  - first DE at h=160,v=23 (+1 cycle) carries pixel 0
  - exactly 1024 pops per line, 600 lines per frame
- Full frame with valid held high:
  - 614400 transfers
  - o_tft_rgb matches the input sequence
  - DE low at h=159 and h=1184
  - o_underrun stays 0
- Drop valid at h=400,v=100:
  - BG_COLOR output with DE high at that pixel
  - o_flush pulses once
  - o_underrun=1, count=1
  - ready stays low until next frame
  - streaming resumes with the first pixel at h=160,v=23 of the next frame
- 300 consecutive frames each with one underrun: o_underrun_count saturates at 255 and does not wrap.
- Deassert i_enabled mid-active-line:
  - ready and DE drop within 1 cycle
  - counters and flag clear
  - re-enable waits for the next (0,0)
- Assert i_reset mid-transfer: all outputs 0 immediately, asynchronously; the block returns to IDLE.
